// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU op codes, FSM state type and op-class helpers.
// Divider support is selected with the MDU_DIV_EN macro.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MDUOP_NONE  = 4'd0,
    MDUOP_MULT  = 4'd1,
    MDUOP_MULTU = 4'd2,
    MDUOP_DIV   = 4'd3,
    MDUOP_DIVU  = 4'd4,
    MDUOP_MTHI  = 4'd5,
    MDUOP_MTLO  = 4'd6,
    MDUOP_MFHI  = 4'd7,
    MDUOP_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_div(input logic [3:0] op);
`ifdef MDU_DIV_EN
    return (op == MDUOP_DIV) || (op == MDUOP_DIVU);
`else
    // Without the divider, DIV/DIVU decode as NONE.
    return (op == 4'hF) && (op != 4'hF);
`endif
  endfunction

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MDUOP_MULT) || (op == MDUOP_MULTU) || is_div(op);
  endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Combinational multiply/divide datapath: {hi,lo} result for the latched op.
// The divide path exists only when MDU_DIV_EN is defined.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o,
  output logic        div_zero_o
);

`ifdef MDU_DIV_EN
  logic [31:0] abs_a, abs_b, dsor, uq, ur, sq, sr;

  // Signed divide on magnitudes; 0x80000000 has magnitude 0x80000000 as unsigned.
  always_comb begin
    abs_a = a_i[31] ? (~a_i + 32'd1) : a_i;
    abs_b = b_i[31] ? (~b_i + 32'd1) : b_i;
    dsor  = (op_i == MDUOP_DIV) ? abs_b : b_i;
    if (dsor == 32'd0) dsor = 32'd1;
    uq = ((op_i == MDUOP_DIV) ? abs_a : a_i) / dsor;
    ur = ((op_i == MDUOP_DIV) ? abs_a : a_i) % dsor;
    sq = (a_i[31] ^ b_i[31]) ? (~uq + 32'd1) : uq;
    sr = a_i[31] ? (~ur + 32'd1) : ur;
  end
`endif

  always_comb begin
    res_o      = '0;
    div_zero_o = 1'b0;
    case (op_i)
      MDUOP_MULT:  res_o = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
      MDUOP_MULTU: res_o = {32'd0, a_i} * {32'd0, b_i};
`ifdef MDU_DIV_EN
      MDUOP_DIV: begin
        res_o      = {sr, sq};
        div_zero_o = (b_i == 32'd0);
      end
      MDUOP_DIVU: begin
        res_o      = {ur, uq};
        div_zero_o = (b_i == 32'd0);
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide control: busy FSM, latency counter, HI/LO.
// Define MDU_DIV_EN to enable DIV/DIVU; otherwise they behave as NONE.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        start,
  output logic        busy,
  output logic [31:0] rdata
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_e     state_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q;
  logic [3:0]     op_q;
  logic [31:0]    a_q, b_q, hi_q, lo_q;
  logic [63:0]    res_d;
  logic           div_zero;

  mdu_arith u_arith (
    .op_i      (op_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .res_o     (res_d),
    .div_zero_o(div_zero)
  );

  assign start = valid & is_muldiv(op) & ~busy_q;
  assign busy  = busy_q;
  assign cnt_d = is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

  always_comb begin
    rdata = 32'd0;
    if (op == MDUOP_MFHI) rdata = hi_q;
    else if (op == MDUOP_MFLO) rdata = lo_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= MDUOP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            cnt_q   <= cnt_d;
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
          end else if (valid && op == MDUOP_MTHI) begin
            hi_q <= a;
          end else if (valid && op == MDUOP_MTLO) begin
            lo_q <= a;
          end
        end
        S_RUN: begin
          // Ops arriving here are hazard violations and are dropped.
          if (cnt_q == CW'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (!div_zero) begin
              hi_q <= res_d[63:32];
              lo_q <= res_d[31:0];
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (default 5/10 cycle latencies).
// DIV scenarios follow MDU_DIV_EN the same way the design does.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [3:0]  op = MDUOP_NONE;
  logic [31:0] a = '0, b = '0;
  logic        start, busy;
  logic [31:0] rdata;
  int          errs = 0, checks = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .a(a), .b(b),
    .start(start), .busy(busy), .rdata(rdata)
  );

  // Inputs change at negedge; outputs sampled 1 time unit later.
  task automatic put(input logic v, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    valid = v; op = o; a = x; b = y;
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    put(1'b0, MDUOP_NONE, 0, 0);
    while (busy && n < 100) begin
      n++;
      put(1'b0, MDUOP_NONE, 0, 0);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    put(1'b0, MDUOP_MFHI, 0, 0);
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL reset_hi got=%h exp=0", rdata); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (start !== 1'b0) begin errs++; $display("FAIL reset_start got=%b exp=0", start); end
    put(1'b0, MDUOP_MFLO, 0, 0);
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL reset_lo got=%h exp=0", rdata); end
    reset = 1'b0;
    put(1'b0, MDUOP_NONE, 0, 0);
  endtask

  task automatic test_mult;
    int n;
    put(1'b1, MDUOP_MULT, 32'hFFFFFFFF, 32'd2);
    checks++; if (start !== 1'b1) begin errs++; $display("FAIL mult_start got=%b exp=1", start); end
    put(1'b0, MDUOP_NONE, 0, 0);
    checks++; if (start !== 1'b0) begin errs++; $display("FAIL mult_start_once got=%b exp=0", start); end
    count_busy(n);
    checks++; if (n != 4) begin errs++; $display("FAIL mult_busy_cycles got=%0d exp=5", n + 1); end
    put(1'b1, MDUOP_MFHI, 0, 0);
    checks++; if (rdata !== 32'hFFFFFFFF) begin errs++; $display("FAIL mult_hi got=%h exp=ffffffff", rdata); end
    put(1'b1, MDUOP_MFLO, 0, 0);
    checks++; if (rdata !== 32'hFFFFFFFE) begin errs++; $display("FAIL mult_lo got=%h exp=fffffffe", rdata); end
    put(1'b1, MDUOP_MULTU, 32'hFFFFFFFF, 32'd2);
    count_busy(n);
    checks++; if (n != 5) begin errs++; $display("FAIL multu_busy_cycles got=%0d exp=5", n); end
    put(1'b1, MDUOP_MFHI, 0, 0);
    checks++; if (rdata !== 32'd1) begin errs++; $display("FAIL multu_hi got=%h exp=1", rdata); end
    put(1'b1, MDUOP_MFLO, 0, 0);
    checks++; if (rdata !== 32'hFFFFFFFE) begin errs++; $display("FAIL multu_lo got=%h exp=fffffffe", rdata); end
  endtask

  task automatic test_div;
    int n;
`ifdef MDU_DIV_EN
    put(1'b1, MDUOP_DIV, 32'hFFFFFFF9, 32'd2);
    checks++; if (start !== 1'b1) begin errs++; $display("FAIL div_start got=%b exp=1", start); end
    count_busy(n);
    checks++; if (n != 10) begin errs++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
    put(1'b1, MDUOP_MFLO, 0, 0);
    checks++; if (rdata !== 32'hFFFFFFFD) begin errs++; $display("FAIL div_lo got=%h exp=fffffffd", rdata); end
    put(1'b1, MDUOP_MFHI, 0, 0);
    checks++; if (rdata !== 32'hFFFFFFFF) begin errs++; $display("FAIL div_hi got=%h exp=ffffffff", rdata); end
    put(1'b1, MDUOP_DIV, 32'h80000000, 32'hFFFFFFFF);
    count_busy(n);
    put(1'b1, MDUOP_MFLO, 0, 0);
    checks++; if (rdata !== 32'h80000000) begin errs++; $display("FAIL div_ovf_lo got=%h exp=80000000", rdata); end
    put(1'b1, MDUOP_MFHI, 0, 0);
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL div_ovf_hi got=%h exp=0", rdata); end
    put(1'b1, MDUOP_DIVU, 32'd100, 32'd7);
    count_busy(n);
    put(1'b1, MDUOP_MFLO, 0, 0);
    checks++; if (rdata !== 32'd14) begin errs++; $display("FAIL divu_lo got=%h exp=e", rdata); end
    put(1'b1, MDUOP_MFHI, 0, 0);
    checks++; if (rdata !== 32'd2) begin errs++; $display("FAIL divu_hi got=%h exp=2", rdata); end
    put(1'b1, MDUOP_DIV, 32'd55, 32'd0);
    count_busy(n);
    checks++; if (n != 10) begin errs++; $display("FAIL div0_busy_cycles got=%0d exp=10", n); end
    put(1'b1, MDUOP_MFLO, 0, 0);
    checks++; if (rdata !== 32'd14) begin errs++; $display("FAIL div0_lo got=%h exp=e", rdata); end
    put(1'b1, MDUOP_MFHI, 0, 0);
    checks++; if (rdata !== 32'd2) begin errs++; $display("FAIL div0_hi got=%h exp=2", rdata); end
`else
    put(1'b1, MDUOP_MTLO, 32'h0000BEEF, 0);
    put(1'b1, MDUOP_DIV, 32'hFFFFFFF9, 32'd2);
    checks++; if (start !== 1'b0) begin errs++; $display("FAIL nodiv_start got=%b exp=0", start); end
    put(1'b0, MDUOP_NONE, 0, 0);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL nodiv_busy got=%b exp=0", busy); end
    put(1'b1, MDUOP_DIVU, 32'd100, 32'd7);
    checks++; if (start !== 1'b0) begin errs++; $display("FAIL nodivu_start got=%b exp=0", start); end
    count_busy(n);
    checks++; if (n != 0) begin errs++; $display("FAIL nodiv_busy_cycles got=%0d exp=0", n); end
    put(1'b1, MDUOP_MFLO, 0, 0);
    checks++; if (rdata !== 32'h0000BEEF) begin errs++; $display("FAIL nodiv_lo got=%h exp=0000beef", rdata); end
`endif
  endtask

  task automatic test_mthi_mtlo;
    put(1'b1, MDUOP_MTHI, 32'h12345678, 0);
    checks++; if (start !== 1'b0) begin errs++; $display("FAIL mthi_start got=%b exp=0", start); end
    put(1'b1, MDUOP_MFHI, 0, 0);
    checks++; if (rdata !== 32'h12345678) begin errs++; $display("FAIL mthi_read got=%h exp=12345678", rdata); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL mthi_busy got=%b exp=0", busy); end
    put(1'b1, MDUOP_MTLO, 32'h11111111, 0);
    put(1'b0, MDUOP_MTHI, 32'hDEADDEAD, 0);
    put(1'b1, MDUOP_MFLO, 0, 0);
    checks++; if (rdata !== 32'h11111111) begin errs++; $display("FAIL mtlo_read got=%h exp=11111111", rdata); end
    put(1'b1, MDUOP_MFHI, 0, 0);
    checks++; if (rdata !== 32'h12345678) begin errs++; $display("FAIL mthi_novalid got=%h exp=12345678", rdata); end
  endtask

  task automatic test_busy_ignore;
    int n;
    put(1'b1, MDUOP_MULT, 32'd3, 32'd4);
    put(1'b1, MDUOP_MTLO, 32'h0000AAAA, 0);
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL ign_busy got=%b exp=1", busy); end
    put(1'b1, MDUOP_MULT, 32'd5, 32'd5);
    checks++; if (start !== 1'b0) begin errs++; $display("FAIL ign_start got=%b exp=0", start); end
    put(1'b1, MDUOP_MFLO, 0, 0);
    checks++; if (rdata !== 32'h11111111) begin errs++; $display("FAIL ign_old_lo got=%h exp=11111111", rdata); end
    // Busy cycles 1..3 consumed; 4 and 5 remain.
    count_busy(n);
    checks++; if (n != 2) begin errs++; $display("FAIL ign_remaining got=%0d exp=2", n); end
    // First idle cycle: back-to-back issue allowed immediately.
    valid = 1'b1; op = MDUOP_MFLO; #1;
    checks++; if (rdata !== 32'd12) begin errs++; $display("FAIL ign_lo got=%h exp=c", rdata); end
    op = MDUOP_MFHI; #1;
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL ign_hi got=%h exp=0", rdata); end
    op = MDUOP_MULTU; a = 32'h00010000; b = 32'h00010000; #1;
    checks++; if (start !== 1'b1) begin errs++; $display("FAIL b2b_start got=%b exp=1", start); end
    count_busy(n);
    checks++; if (n != 5) begin errs++; $display("FAIL b2b_busy_cycles got=%0d exp=5", n); end
    put(1'b1, MDUOP_MFHI, 0, 0);
    checks++; if (rdata !== 32'd1) begin errs++; $display("FAIL b2b_hi got=%h exp=1", rdata); end
    put(1'b1, MDUOP_MFLO, 0, 0);
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL b2b_lo got=%h exp=0", rdata); end
  endtask

  task automatic test_reset_mid;
    int n;
    put(1'b1, MDUOP_MTHI, 32'hCAFEF00D, 0);
    put(1'b1, MDUOP_MTLO, 32'h0BADF00D, 0);
`ifdef MDU_DIV_EN
    put(1'b1, MDUOP_DIV, 32'd1000, 32'd3);
`else
    put(1'b1, MDUOP_MULT, 32'd1000, 32'd3);
`endif
    put(1'b0, MDUOP_NONE, 0, 0);
    put(1'b0, MDUOP_NONE, 0, 0);
    put(1'b0, MDUOP_MFHI, 0, 0);
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL rmid_pre_busy got=%b exp=1", busy); end
    reset = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL rmid_hi got=%h exp=0", rdata); end
    op = MDUOP_MFLO; #1;
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL rmid_lo got=%h exp=0", rdata); end
    put(1'b0, MDUOP_NONE, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) put(1'b0, MDUOP_NONE, 0, 0);
    count_busy(n);
    checks++; if (n != 0) begin errs++; $display("FAIL rmid_after_busy got=%0d exp=0", n); end
    put(1'b1, MDUOP_MFLO, 0, 0);
    checks++; if (rdata !== 32'd0) begin errs++; $display("FAIL rmid_discard_lo got=%h exp=0", rdata); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_mthi_mtlo;
    test_busy_ignore;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide unit for the E stage of the pipelined MIPS core. It accepts one MDU instruction per issue and owns the HI/LO registers. It models `mult`/`div` latency with a down-counter and a `busy` flag, which the hazard unit uses to stall subsequent MDU instructions. It also serves `mthi`/`mtlo`/`mfhi`/`mflo`.

## Interface
- `MULT_CYCLES`, default 5: busy cycles after a `mult`/`multu` issue.
- `DIV_CYCLES`, default 10: busy cycles after a `div`/`divu` issue.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `valid`  in  1  E-stage instruction is real (not a bubble or flushed).
- `op`  in  4  `MDUOP_*` code: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- `a`  in  32  rs operand.
- `b`  in  32  rt operand.
- `start`  out  1  combinational: `valid` & op is MULT/MULTU/DIV/DIVU & `~busy`.
- `busy`  out  1  registered; high while a multiply/divide is in flight.
- `rdata`  out  32  combinational: HI for MFHI, LO for MFLO, else 0.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, counter `cnt` nonzero.
- IDLE → RUN on `start`:
  - latch `a`, `b` and the op;
  - load `cnt` with MULT_CYCLES or DIV_CYCLES.
- In RUN, `cnt` decrements every cycle. At the edge where `cnt`==1:
  - write HI/LO from the latched operands;
  - `cnt`→0, state→IDLE.
- Arithmetic:
  - MULT: {HI,LO} = signed 32×32→64.
  - MULTU: {HI,LO} = unsigned 32×32→64.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: the instruction runs the full DIV_CYCLES and leaves HI/LO unchanged.
- MTHI/MTLO with `valid` & `~busy`: HI/LO ← `a` at that edge. No busy cycles.
- Any MULT/DIV/MTHI/MTLO presented while `busy` is a hazard-unit violation. The block ignores it: no state change, no `start`.
- MFHI/MFLO while `busy` return the pre-operation HI/LO. The hazard unit must stall them.
- `valid`=0 or op=NONE: no effect.

## Timing
- Reset values:
  - `busy`=0, `cnt`=0, HI=0, LO=0, state IDLE;
  - hence `start`=0 when `valid`=0, and `rdata`=0 for non-MF ops.
- An issue at edge T0 sets `busy`=1 for cycles T0+1 … T0+N, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO update at edge T0+N. `busy` is 0 in the following cycle, and MFHI/MFLO then read the new value.
- A back-to-back MDU op may `start` in the first cycle with `busy`=0.
- An MTHI/MTLO written at edge T is visible on `rdata` from cycle T+1.
- Reset asserted mid-RUN clears everything immediately. The pending result is discarded.
- `cnt` width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

## Configuration
- `MDU_DIV_EN` defined:
  - DIV/DIVU are supported as specified above.
- `MDU_DIV_EN` undefined:
  - the divider is not instantiated;
  - DIV/DIVU are treated as NONE: `start`=0, no busy cycles, HI/LO unchanged;
  - DIV_CYCLES is unused.

## Structure
- `MDUOP_*` codes (4-bit) go in the shared `macros.v`, alongside the existing `EXTOP_*` definitions. The control decoder uses the same codes.
- One sub-module, `mdu_arith`:
  - purely combinational;
  - inputs: the latched operands and op;
  - outputs: 64-bit {hi,lo} and a `div_zero` flag;
  - the divide path sits inside `ifdef MDU_DIV_EN`.
- `mdu_ctrl` holds the FSM, counter, operand latches and HI/LO.

## Test plan
- Reset, then MFHI/MFLO → `rdata`=0, `busy`=0.
- MULT, a=0xFFFFFFFF, b=2:
  - `start`=1 for one cycle, `busy`=1 for exactly 5 cycles;
  - afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE;
  - MULTU with the same operands → HI=1, LO=0xFFFFFFFE.
- DIV, a=0xFFFFFFF9 (−7), b=2:
  - 10 busy cycles;
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF;
  - DIV by b=0 → HI/LO unchanged after 10 cycles.
- MTHI a=0x12345678, then MFHI next cycle → `rdata`=0x12345678.
- During `busy`:
  - MTLO 0xAAAA and MULT are ignored;
  - MFLO shows the old LO;
  - LO after completion equals the first operation's result.
- Assert `reset` at busy cycle 3 of a DIV → `busy`=0 immediately, HI=LO=0.
- With `MDU_DIV_EN` undefined: DIV → `start`=0, `busy` stays 0, HI/LO unchanged.
